// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morse_pkg
// Description : Shared types and constants for the Morse character sequencer.
//               Covers the collector state, the symbol length limit, the ASCII
//               codes used for space and error, and the element bit encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int MAX_LEN_DEF = 6;

  // Fixed key width of the lookup table: {len[2:0], pattern[5:0]}
  localparam int LUT_LEN_W = 3;
  localparam int LUT_PAT_W = 6;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ERR   = 8'h3F;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

endpackage
`default_nettype wire

// File: rtl/morse_char_sequencer_lut.sv
`default_nettype none
// ============================================================================
// Module      : morse_char_sequencer_lut
// Description : Combinational Morse code lookup. The symbol is given as its
//               element count and a right-aligned pattern in which the first
//               element sits at bit len-1 (dot=0, dash=1).
// Ports       : len     in  3  number of elements in the symbol
//               pattern in  6  element bits, right-aligned
//               ascii   out 8  decoded character (0x00 on miss)
//               hit     out 1  symbol is a known letter or digit
// Revision    : 1.0 - initial release
// ============================================================================
module morse_char_sequencer_lut
  import morse_pkg::*;
(
  input  logic [LUT_LEN_W-1:0] len,
  input  logic [LUT_PAT_W-1:0] pattern,
  output logic [7:0]           ascii,
  output logic                 hit
);

  always_comb begin
    ascii = 8'h00;
    hit   = 1'b1;
    case ({len, pattern})
      {3'd2, 6'b000001}: ascii = 8'h41; // A .-
      {3'd4, 6'b001000}: ascii = 8'h42; // B -...
      {3'd4, 6'b001010}: ascii = 8'h43; // C -.-.
      {3'd3, 6'b000100}: ascii = 8'h44; // D -..
      {3'd1, 6'b000000}: ascii = 8'h45; // E .
      {3'd4, 6'b000010}: ascii = 8'h46; // F ..-.
      {3'd3, 6'b000110}: ascii = 8'h47; // G --.
      {3'd4, 6'b000000}: ascii = 8'h48; // H ....
      {3'd2, 6'b000000}: ascii = 8'h49; // I ..
      {3'd4, 6'b000111}: ascii = 8'h4A; // J .---
      {3'd3, 6'b000101}: ascii = 8'h4B; // K -.-
      {3'd4, 6'b000100}: ascii = 8'h4C; // L .-..
      {3'd2, 6'b000011}: ascii = 8'h4D; // M --
      {3'd2, 6'b000010}: ascii = 8'h4E; // N -.
      {3'd3, 6'b000111}: ascii = 8'h4F; // O ---
      {3'd4, 6'b000110}: ascii = 8'h50; // P .--.
      {3'd4, 6'b001101}: ascii = 8'h51; // Q --.-
      {3'd3, 6'b000010}: ascii = 8'h52; // R .-.
      {3'd3, 6'b000000}: ascii = 8'h53; // S ...
      {3'd1, 6'b000001}: ascii = 8'h54; // T -
      {3'd3, 6'b000001}: ascii = 8'h55; // U ..-
      {3'd4, 6'b000001}: ascii = 8'h56; // V ...-
      {3'd3, 6'b000011}: ascii = 8'h57; // W .--
      {3'd4, 6'b001001}: ascii = 8'h58; // X -..-
      {3'd4, 6'b001011}: ascii = 8'h59; // Y -.--
      {3'd4, 6'b001100}: ascii = 8'h5A; // Z --..
      {3'd5, 6'b011111}: ascii = 8'h30; // 0 -----
      {3'd5, 6'b001111}: ascii = 8'h31; // 1 .----
      {3'd5, 6'b000111}: ascii = 8'h32; // 2 ..---
      {3'd5, 6'b000011}: ascii = 8'h33; // 3 ...--
      {3'd5, 6'b000001}: ascii = 8'h34; // 4 ....-
      {3'd5, 6'b000000}: ascii = 8'h35; // 5 .....
      {3'd5, 6'b010000}: ascii = 8'h36; // 6 -....
      {3'd5, 6'b011000}: ascii = 8'h37; // 7 --...
      {3'd5, 6'b011100}: ascii = 8'h38; // 8 ---..
      {3'd5, 6'b011110}: ascii = 8'h39; // 9 ----.
      default:           hit   = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/morse_char_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : morse_char_sequencer
// Description : Collects dot/dash pulses into a symbol, resolves the symbol to
//               ASCII on a letter or word gap, inserts one space per word gap
//               and presents characters on a one-entry valid/ready slot.
// Ports       : clk, reset_n                 clock, async active-low reset
//               dot_in, dash_in, lg_in, wg_in one-cycle element/gap pulses
//               char_data, char_valid         output character slot
//               char_ready                    downstream accept
//               clr_err                       clear sticky error flags
//               overrun, too_long             sticky error flags
//               busy                          symbol or space in progress
// Revision    : 1.0 - initial release
// ============================================================================
module morse_char_sequencer
  import morse_pkg::*;
#(
  parameter int         MAX_LEN  = MAX_LEN_DEF, // 2..7
  parameter logic [7:0] ERR_CHAR = ASCII_ERR
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dot_in,
  input  logic       dash_in,
  input  logic       lg_in,
  input  logic       wg_in,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  input  logic       clr_err,
  output logic       overrun,
  output logic       too_long,
  output logic       busy
);

  localparam int LEN_W = LUT_LEN_W;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [MAX_LEN-1:0]   pattern_q, pattern_d;
  logic                 invalid_q, invalid_d;
  logic                 space_pend_q, space_pend_d;
  logic                 last_space_q, last_space_d;
  logic [7:0]           char_data_q, char_data_d;
  logic                 char_valid_q, char_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 too_long_q, too_long_d;

  logic                 elem;
  logic                 elem_bit;
  logic                 char_load;
  logic                 space_req;
  logic                 slot_free;
  logic                 too_long_set;
  logic                 overrun_set;
  logic [7:0]           resolved;
  logic [7:0]           lut_ascii;
  logic                 lut_hit;
  logic [LUT_PAT_W-1:0] lut_pattern;

  assign lut_pattern = LUT_PAT_W'(pattern_q);

  morse_char_sequencer_lut u_lut (
    .len     (len_q),
    .pattern (lut_pattern),
    .ascii   (lut_ascii),
    .hit     (lut_hit)
  );

  assign resolved  = (invalid_q || !lut_hit) ? ERR_CHAR : lut_ascii;
  assign slot_free = ~char_valid_q | char_ready;
  assign elem      = dot_in | dash_in;
  assign elem_bit  = dash_in ? DASH : DOT; // dash wins when both pulse

  // Symbol collection FSM
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    pattern_d    = pattern_q;
    invalid_d    = invalid_q;
    char_load    = 1'b0;
    space_req    = 1'b0;
    too_long_set = 1'b0;
    case (state_q)
      IDLE: begin
        // A space is only worth requesting if the last output was not one
        if (wg_in && !last_space_q) space_req = 1'b1;
        if (elem) begin
          len_d     = LEN_W'(1);
          pattern_d = {{(MAX_LEN-1){1'b0}}, elem_bit};
          invalid_d = 1'b0;
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        if (lg_in || wg_in) begin
          // The gap closes the current symbol; a coincident element opens
          // the next one.
          char_load = 1'b1;
          space_req = wg_in;
          invalid_d = 1'b0;
          if (elem) begin
            len_d     = LEN_W'(1);
            pattern_d = {{(MAX_LEN-1){1'b0}}, elem_bit};
          end else begin
            len_d     = '0;
            pattern_d = '0;
            state_d   = IDLE;
          end
        end else if (elem) begin
          if (len_q == LEN_W'(MAX_LEN)) begin
            too_long_set = 1'b1;
            invalid_d    = 1'b1;
          end else begin
            len_d     = len_q + LEN_W'(1);
            pattern_d = {pattern_q[MAX_LEN-2:0], elem_bit};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slot: resolved character has priority over a pending space
  always_comb begin
    char_data_d  = char_data_q;
    char_valid_d = char_valid_q;
    space_pend_d = space_pend_q;
    last_space_d = last_space_q;
    overrun_set  = 1'b0;
    if (char_load) begin
      if (slot_free) begin
        char_data_d  = resolved;
        char_valid_d = 1'b1;
        last_space_d = 1'b0;
      end else begin
        overrun_set  = 1'b1;
      end
    end else if (space_pend_q && slot_free) begin
      char_data_d  = ASCII_SPACE;
      char_valid_d = 1'b1;
      space_pend_d = 1'b0;
      last_space_d = 1'b1;
    end else if (char_valid_q && char_ready) begin
      char_valid_d = 1'b0;
    end
    if (space_req) space_pend_d = 1'b1;

    // A set event in the same cycle as clr_err wins
    overrun_d  = overrun_set  ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    too_long_d = too_long_set ? 1'b1 : (clr_err ? 1'b0 : too_long_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      pattern_q    <= '0;
      invalid_q    <= 1'b0;
      space_pend_q <= 1'b0;
      last_space_q <= 1'b1;
      char_data_q  <= 8'h00;
      char_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      too_long_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      pattern_q    <= pattern_d;
      invalid_q    <= invalid_d;
      space_pend_q <= space_pend_d;
      last_space_q <= last_space_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
      overrun_q    <= overrun_d;
      too_long_q   <= too_long_d;
    end
  end

  assign char_data  = char_data_q;
  assign char_valid = char_valid_q;
  assign overrun    = overrun_q;
  assign too_long   = too_long_q;
  assign busy       = (state_q == COLLECT) | space_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_char_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_char_sequencer
// Description : Self-checking bench for morse_char_sequencer. A reference
//               model keeps the current symbol as a dot/dash string decoded
//               through a dictionary; loaded characters are queued and
//               compared by a monitor whenever a handshake is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_char_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dot_in = 1'b0, dash_in = 1'b0, lg_in = 1'b0, wg_in = 1'b0;
  logic       char_ready = 1'b0, clr_err = 1'b0;
  logic [7:0] char_data;
  logic       char_valid, overrun, too_long, busy;

  int tests = 0;
  int fails = 0;

  morse_char_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dot_in     (dot_in),
    .dash_in    (dash_in),
    .lg_in      (lg_in),
    .wg_in      (wg_in),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .clr_err    (clr_err),
    .overrun    (overrun),
    .too_long   (too_long),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] dict [string];
  string      m_sym;
  bit         m_inv, m_valid, m_space_pend, m_last_space, m_over, m_tl;
  logic [7:0] exp_q [$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] decode(string s, bit inv);
    if (inv || !dict.exists(s)) return 8'h3F;
    return dict[s];
  endfunction

  function automatic void model_reset();
    m_sym = ""; m_inv = 0; m_valid = 0; m_space_pend = 0;
    m_last_space = 1; m_over = 0; m_tl = 0;
    exp_q.delete();
  endfunction

  function automatic void model_step();
    bit collecting = (m_sym.len() > 0);
    bit slot_free  = !m_valid || char_ready;
    bit load = 0, sp_set = 0, tl_set = 0, ov_set = 0;
    logic [7:0] ch = 8'h00;
    string e;
    if (collecting && (lg_in || wg_in)) begin
      load = 1;
      ch = decode(m_sym, m_inv);
      sp_set = wg_in;
      m_sym = "";
      m_inv = 0;
    end else if (!collecting && wg_in && !m_last_space) begin
      sp_set = 1;
    end
    if (dot_in || dash_in) begin
      e = dash_in ? "-" : ".";
      if (m_sym.len() == 6) begin
        tl_set = 1;
        m_inv = 1;
      end else begin
        m_sym = {m_sym, e};
      end
    end
    if (load) begin
      if (slot_free) begin
        m_valid = 1; m_last_space = 0; exp_q.push_back(ch);
      end else begin
        ov_set = 1;
      end
    end else if (m_space_pend && slot_free) begin
      m_valid = 1; m_space_pend = 0; m_last_space = 1; exp_q.push_back(8'h20);
    end else if (m_valid && char_ready) begin
      m_valid = 0;
    end
    if (sp_set) m_space_pend = 1;
    m_over = ov_set ? 1'b1 : (clr_err ? 1'b0 : m_over);
    m_tl   = tl_set ? 1'b1 : (clr_err ? 1'b0 : m_tl);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  // ---------------- monitor / scoreboard ----------------
  // Inputs change just after the rising edge, so at the falling edge both
  // char_valid and char_ready show what the next rising edge will use.
  always @(negedge clk) begin
    chk("valid", {31'd0, char_valid}, {31'd0, m_valid});
    chk("overrun", {31'd0, overrun}, {31'd0, m_over});
    chk("too_long", {31'd0, too_long}, {31'd0, m_tl});
    chk("busy", {31'd0, busy}, {31'd0, (m_sym.len() > 0) || m_space_pend});
    if (!reset_n) begin
      chk("reset_data", {24'd0, char_data}, 32'h0);
    end else if (char_valid && char_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_char: got %0h expected none at %0t", char_data, $time);
      end else begin
        chk("char", {24'd0, char_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input byte c);
    dot_in  = (c == ".");
    dash_in = (c == "-");
    lg_in   = (c == "l");
    wg_in   = (c == "w");
    tick();
    dot_in = 0; dash_in = 0; lg_in = 0; wg_in = 0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) pulse(s[i]);
  endtask

  initial begin
    string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                          "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                          "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                          "-.--", "--..", "-----", ".----", "..---", "...--",
                          "....-", ".....", "-....", "--...", "---..", "----."};
    for (int i = 0; i < 36; i++)
      dict[codes[i]] = (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
    model_reset();

    // Reset state
    repeat (3) tick();
    chk("rst_valid", {31'd0, char_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {24'd0, char_data}, 32'h0);
    reset_n = 1;
    tick();

    // 'A' with one-cycle latency and one-cycle valid
    char_ready = 1;
    send(".-");
    pulse("l");
    chk("A_data", {24'd0, char_data}, 32'h41);
    chk("A_valid", {31'd0, char_valid}, 32'd1);
    tick();
    chk("A_valid_drop", {31'd0, char_valid}, 32'd0);

    // SOS then word gap, then a redundant word gap
    send("...l---l...lw");
    repeat (3) tick();
    send("w");
    repeat (3) tick();
    chk("sos_busy", {31'd0, busy}, 32'd0);

    // Overrun: 'E' held, 'T' lost
    char_ready = 0;
    send(".l-l");
    tick();
    chk("E_held", {24'd0, char_data}, 32'h45);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    clr_err = 1; tick(); clr_err = 0;
    chk("overrun_clr", {31'd0, overrun}, 32'd0);
    char_ready = 1;
    repeat (2) tick();

    // Over-length symbol, then an unknown code within the limit
    send(".......l");
    tick();
    chk("too_long_set", {31'd0, too_long}, 32'd1);
    clr_err = 1; tick(); clr_err = 0;
    send("----..l");
    tick();
    chk("too_long_kept", {31'd0, too_long}, 32'd0);
    repeat (2) tick();

    // 'T' and a pending space behind a stalled slot
    char_ready = 0;
    send("-w");
    chk("T_held", {24'd0, char_data}, 32'h54);
    chk("T_busy", {31'd0, busy}, 32'd1);
    char_ready = 1;
    tick();
    chk("space_next", {24'd0, char_data}, 32'h20);
    chk("space_valid", {31'd0, char_valid}, 32'd1);
    tick();
    chk("space_done_busy", {31'd0, busy}, 32'd0);
    chk("space_done_valid", {31'd0, char_valid}, 32'd0);

    // Reset mid-symbol discards everything
    send(".--");
    reset_n = 0;
    tick();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1;
    tick();
    send("l");
    repeat (2) tick();
    chk("midrst_novalid", {31'd0, char_valid}, 32'd0);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      int r = $urandom_range(0, 99);
      dot_in     = (r < 30) || (r >= 55 && r < 60);
      dash_in    = (r >= 30 && r < 60);
      lg_in      = (r >= 60 && r < 78) || (r >= 95);
      wg_in      = (r >= 78 && r < 84);
      char_ready = ($urandom_range(0, 3) != 0);
      clr_err    = ($urandom_range(0, 49) == 0);
      tick();
    end
    dot_in = 0; dash_in = 0; lg_in = 0; wg_in = 0; clr_err = 0;
    char_ready = 1;
    send("l");
    repeat (10) tick();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
